// File: rtl/gpio_receiver.sv
// gpio_receiver: deserialises the 3-word GPIO messenger frame into a text byte and a 32-bit audio sample
// Ports: FPGA_clock/reset (sync, active-high); rx_pins[17]=forwarded GPIO clock, [16]=frame-active, [15:0]=data;
// text_out/text_ready_out, audio_out/audio_ready_out, receiving, frame_error (one-cycle pulse on abort).
// Optional: define GPIO_RX_FRAME_COUNT_EN to add frame_count[15:0], incremented on every committed frame.
module gpio_receiver #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        FPGA_clock,
    input  logic        reset,
    input  logic [17:0] rx_pins,
    output logic [7:0]  text_out,
    output logic        text_ready_out,
    output logic [31:0] audio_out,
    output logic        audio_ready_out,
    output logic        receiving,
    output logic        frame_error
`ifdef GPIO_RX_FRAME_COUNT_EN
    ,
    output logic [15:0] frame_count
`endif
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, HI, LO, TAIL} state_t;
    state_t        state_q, state_d;
    logic [17:0]   sync_q [SYNC_STAGES];
    logic [17:0]   pins;
    logic          clk_prev_q;
    logic          ev, active, timeout;
    logic [1:0]    flags_q, flags_d;
    logic [7:0]    text_sh_q, text_sh_d;
    logic [31:0]   audio_sh_q, audio_sh_d;
    logic          commit_q, commit_d, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign pins    = sync_q[SYNC_STAGES-1];
    // Falling edge of the synced GPIO clock marks mid-bit, where data is stable
    assign ev      = clk_prev_q & ~pins[17];
    assign active  = pins[16];
    assign timeout = (state_q == HI || state_q == LO) && cnt_q == CW'(TIMEOUT_CYCLES);

    always_comb begin
        state_d    = state_q;
        flags_d    = flags_q;
        text_sh_d  = text_sh_q;
        audio_sh_d = audio_sh_q;
        commit_d   = 1'b0;
        err_d      = 1'b0;
        cnt_d      = ev ? '0 : (state_q == HI || state_q == LO) && !timeout ? cnt_q + 1'b1 : cnt_q;
        if (ev) begin
            case (state_q)
                IDLE, TAIL: begin
                    // A set frame-active bit in TAIL is a missing tail: flag it and restart on this word
                    err_d   = state_q == TAIL && active;
                    state_d = active ? HI : IDLE;
                    if (active) begin
                        flags_d   = pins[15:14];
                        text_sh_d = pins[7:0];
                    end
                end
                HI: begin
                    err_d   = !active;
                    state_d = active ? LO : IDLE;
                    if (active) audio_sh_d[31:16] = pins[15:0];
                end
                default: begin
                    err_d    = !active;
                    commit_d = active;
                    state_d  = active ? TAIL : IDLE;
                    if (active) audio_sh_d[15:0] = pins[15:0];
                end
            endcase
        end else if (timeout) begin
            err_d   = 1'b1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge FPGA_clock) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            clk_prev_q      <= 1'b0;
            state_q         <= IDLE;
            flags_q         <= '0;
            text_sh_q       <= '0;
            audio_sh_q      <= '0;
            commit_q        <= 1'b0;
            cnt_q           <= '0;
            text_out        <= '0;
            text_ready_out  <= 1'b0;
            audio_out       <= '0;
            audio_ready_out <= 1'b0;
            receiving       <= 1'b0;
            frame_error     <= 1'b0;
        end else begin
            sync_q[0] <= rx_pins;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            clk_prev_q      <= pins[17];
            state_q         <= state_d;
            flags_q         <= flags_d;
            text_sh_q       <= text_sh_d;
            audio_sh_q      <= audio_sh_d;
            commit_q        <= commit_d;
            cnt_q           <= cnt_d;
            text_out        <= commit_q && flags_q[1] ? text_sh_q : text_out;
            text_ready_out  <= commit_q && flags_q[1];
            audio_out       <= commit_q && flags_q[0] ? audio_sh_q : audio_out;
            audio_ready_out <= commit_q && flags_q[0];
            receiving       <= state_d != IDLE;
            frame_error     <= err_d;
        end
    end

`ifdef GPIO_RX_FRAME_COUNT_EN
    logic [15:0] frame_count_q;
    always_ff @(posedge FPGA_clock) begin
        if (reset) frame_count_q <= '0;
        else if (commit_q) frame_count_q <= frame_count_q + 1'b1;
    end
    assign frame_count = frame_count_q;
`endif
endmodule

// File: tb/tb_gpio_receiver.sv
// tb_gpio_receiver: directed and randomised frames against a frame-level reference model
module tb_gpio_receiver;
    localparam int NS = 2;
    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [17:0] rx_pins = '0;
    logic [7:0]  text_out;
    logic        text_ready_out;
    logic [31:0] audio_out;
    logic        audio_ready_out;
    logic        receiving;
    logic        frame_error;
`ifdef GPIO_RX_FRAME_COUNT_EN
    logic [15:0] frame_count;
`endif

    gpio_receiver #(.SYNC_STAGES(NS), .TIMEOUT_CYCLES(TO)) dut (
        .FPGA_clock(clk),
        .reset(reset),
        .rx_pins(rx_pins),
        .text_out(text_out),
        .text_ready_out(text_ready_out),
        .audio_out(audio_out),
        .audio_ready_out(audio_ready_out),
        .receiving(receiving),
        .frame_error(frame_error)
`ifdef GPIO_RX_FRAME_COUNT_EN
        ,
        .frame_count(frame_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tr = 0, n_ar = 0, n_both = 0, n_err = 0, lat = 0, w2_cyc = 0;
    always @(negedge clk) begin
        if (text_ready_out) n_tr++;
        if (audio_ready_out) n_ar++;
        if (text_ready_out && audio_ready_out) n_both++;
        if (frame_error) n_err++;
        if (text_ready_out || audio_ready_out) lat = cyc - w2_cyc;
    end

    int checks = 0, errors = 0;
    logic [7:0]  exp_text = '0;
    logic [31:0] exp_audio = '0;
    logic [15:0] exp_fc = '0;
    int exp_tr = 0, exp_ar = 0, exp_both = 0, exp_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".text_out"}, 64'(text_out), 64'(exp_text));
        check({tag, ".audio_out"}, 64'(audio_out), 64'(exp_audio));
        check({tag, ".text_pulses"}, 64'(n_tr), 64'(exp_tr));
        check({tag, ".audio_pulses"}, 64'(n_ar), 64'(exp_ar));
        check({tag, ".both_pulses"}, 64'(n_both), 64'(exp_both));
        check({tag, ".errors"}, 64'(n_err), 64'(exp_err));
`ifdef GPIO_RX_FRAME_COUNT_EN
        check({tag, ".frame_count"}, 64'(frame_count), 64'(exp_fc));
`endif
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One GPIO clock period: pins change with the rising edge, sampled by the DUT at the falling edge
    task automatic send_word(input logic b16, input logic [15:0] d, input bit is_w2);
        int h;
        h = $urandom_range(NS + 3, NS + 6);
        rx_pins = {1'b1, b16, d};
        tick(h);
        rx_pins[17] = 1'b0;
        if (is_w2) w2_cyc = cyc;
        tick(h);
    endtask

    task automatic model_commit(input logic [1:0] f, input logic [7:0] t, input logic [31:0] a);
        exp_fc = exp_fc + 16'd1;
        if (f[1]) begin exp_text = t; exp_tr++; end
        if (f[0]) begin exp_audio = a; exp_ar++; end
        if (f == 2'b11) exp_both++;
    endtask

    task automatic send_frame(input logic [1:0] f, input logic [7:0] t, input logic [31:0] a, input bit tail);
        send_word(1'b1, {f, 6'($urandom), t}, 1'b0);
        send_word(1'b1, a[31:16], 1'b0);
        send_word(1'b1, a[15:0], 1'b1);
        model_commit(f, t, a);
        check("receiving_before_tail", 64'(receiving), 64'd1);
        if (tail) begin
            send_word(1'b0, 16'($urandom), 1'b0);
            check("receiving_after_tail", 64'(receiving), 64'd0);
        end
    endtask

    task automatic model_reset();
        exp_text = '0;
        exp_audio = '0;
        exp_fc = '0;
    endtask

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation did not finish, cyc=%0d expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] f;
        tick(3);
        check("reset.receiving", 64'(receiving), 64'd0);
        check("reset.ready", 64'({text_ready_out, audio_ready_out, frame_error}), 64'd0);
        check_all("reset");
        reset = 1'b0;
        tick(4);
        check_all("after_reset_idle");

        send_frame(2'b11, 8'h41, 32'hDEADBEEF, 1'b1);
        check("both_latency", 64'(lat), 64'(NS + 2));
        check_all("frame_11");

        send_frame(2'b10, 8'h7A, 32'h12345678, 1'b1);
        check("text_latency", 64'(lat), 64'(NS + 2));
        check_all("frame_10");

        send_word(1'b1, {2'b11, 6'h0, 8'h99}, 1'b0);
        send_word(1'b1, 16'h1111, 1'b0);
        send_word(1'b0, 16'h2222, 1'b0);
        exp_err++;
        check("abort_w2.receiving", 64'(receiving), 64'd0);
        check_all("abort_w2");

        send_frame(2'b01, 8'h00, 32'hCAFEF00D, 1'b1);
        check("audio_latency", 64'(lat), 64'(NS + 2));
        check_all("frame_01");

        send_word(1'b1, {2'b11, 6'h0, 8'hEE}, 1'b0);
        rx_pins = {2'b11, 16'h3333};
        tick(5);
        check("timeout.receiving_mid", 64'(receiving), 64'd1);
        tick(TO + 5);
        exp_err++;
        check("timeout.receiving", 64'(receiving), 64'd0);
        rx_pins = '0;
        tick(10);
        check_all("timeout");

        send_frame(2'b11, 8'h12, 32'h0BADF00D, 1'b0);
        send_frame(2'b10, 8'h34, 32'h0, 1'b1);
        exp_err++;
        check_all("missing_tail");

        send_frame(2'b00, 8'hAA, 32'hFFFFFFFF, 1'b1);
        check_all("frame_00");

        send_word(1'b1, {2'b11, 6'h0, 8'h77}, 1'b0);
        send_word(1'b1, 16'h7777, 1'b0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        model_reset();
        check("midreset.receiving", 64'(receiving), 64'd0);
        check_all("midreset");
        tick(6);
        check_all("midreset_quiet");
        send_frame(2'b11, 8'h55, 32'h00010002, 1'b1);
        check_all("after_midreset");

        for (int i = 0; i < 40; i++) begin
            f = 2'($urandom);
            send_frame(f, 8'($urandom), $urandom, 1'b1);
            if ($urandom_range(0, 2) == 0) send_word(1'b0, 16'($urandom), 1'b0);
            check_all("random");
        end

        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 300; i++) begin
            send_frame({1'b1, 1'($urandom)}, 8'($urandom), $urandom, 1'b1);
            send_word(1'b0, 16'($urandom), 1'b0);
        end
        check_all("burst300");
`ifdef GPIO_RX_FRAME_COUNT_EN
        check("burst300.count", 64'(frame_count), 64'd300);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gpio_receiver.md
Name: gpio_receiver

Overview:
- Receive side of the 18-pin GPIO messenger link. Deserialises the 3-word frame driven by the far board's transmitter into one text byte and one 32-bit audio sample.
- Runs entirely on FPGA_clock. It oversamples the forwarded GPIO clock (pin 17) and does not use that clock as a clock.
- Sits between the GPIO header and the text display and audio playback paths.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser applied to all 18 pins. Legal values are 2 or more.
- TIMEOUT_CYCLES, 4096, number of FPGA_clock cycles without a sampled pin-17 falling edge while mid-frame before the frame is aborted.

Ports:
- FPGA_clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- rx_pins  input  18  raw GPIO pins. Bit 17 is the forwarded GPIO clock, bit 16 is frame-active, bits 15:0 are data.
- text_out  output  8  last received text byte.
- text_ready_out  output  1  one-cycle pulse; text_out is new.
- audio_out  output  32  last received audio sample.
- audio_ready_out  output  1  one-cycle pulse; audio_out is new.
- receiving  output  1  high while a frame is in progress.
- frame_error  output  1  one-cycle pulse on an aborted frame.

Behaviour:
- Synchroniser and sampling
  - All 18 pins pass through a SYNC_STAGES chain, so data stays aligned with the clock bit.
  - The edge detector keeps the previous synced pin 17. A "sample event" is prev=1 and cur=0 in the same cycle.
  - The transmitter changes pins on the GPIO rising edge, so data is sampled at the falling edge, mid-bit.
- Requirement on the link: the GPIO half-period must be at least SYNC_STAGES+3 FPGA_clock cycles.
- Frame format, one word per sample event:
  - W0: bit16=1, bits15:14 = {text_flag, audio_flag}, bits7:0 = text. Bits 13:8 are don't-care.
  - W1: bit16=1, bits15:0 = audio[31:16].
  - W2: bit16=1, bits15:0 = audio[15:0].
  - Tail: bit16=0.
- FSM states: IDLE, HI, LO, TAIL. All transitions below happen only on a sample event, except timeout and reset.
  - IDLE: if bit16=1, latch the flags and text into shadow registers, go to HI. Otherwise stay.
  - HI: if bit16=1, latch shadow audio[31:16] and go to LO. Otherwise pulse frame_error and go to IDLE.
  - LO: if bit16=1, latch shadow audio[15:0] and go to TAIL, and commit in the next cycle. Otherwise pulse frame_error and go to IDLE.
  - TAIL: if bit16=0, go to IDLE. If bit16=1, pulse frame_error and treat the word as a new W0, going to HI.
- Commit (cycle after the LO sample event):
  - If text_flag: load text_out from shadow and pulse text_ready_out.
  - If audio_flag: load audio_out from shadow and pulse audio_ready_out.
  - Both flags set: both pulses fire in the same cycle.
  - Both flags 0: the frame completes with no pulse and no error.
  - text_out and audio_out hold their values between commits. A partial or aborted frame never changes them.
- receiving is registered, high in HI, LO and TAIL.
- Timeout: a counter clears on every sample event and counts in HI and LO. When it reaches TIMEOUT_CYCLES it pulses frame_error and goes to IDLE. The count saturates and never wraps.
- Reset values:
  - State IDLE.
  - All outputs 0.
  - Synchroniser, edge history, shadows and counter 0.
  - Reset mid-frame discards the frame. No pulse is issued.
  - After reset, a pin 17 already low gives no spurious event, because prev is 0.
- Latency: from a pin-17 falling edge at the pins to the pulse is SYNC_STAGES+2 FPGA_clock cycles after the W2 edge.

Optional Feature:
- Macro GPIO_RX_FRAME_COUNT_EN.
- Defined: adds output frame_count [15:0], reset 0. It increments on every commit cycle, including frames with both flags 0, and wraps 0xFFFF to 0x0000.
- Undefined: no port and no counter logic. All other behaviour is identical.

Test Plan:
- Frame with flags 2'b11, text 0x41, audio words 0xDEAD then 0xBEEF -> text_out=0x41 and audio_out=0xDEADBEEF. Both ready pulses fire for exactly 1 cycle in the same cycle; receiving falls after the tail.
- Flags 2'b10, text 0x7A, audio 0x1234/0x5678 -> text_ready_out pulses and text_out=0x7A. No audio pulse, and audio_out keeps its prior value.
- Bit16 drops at the W2 edge -> frame_error pulses once with no ready pulses and outputs unchanged. The next good frame with flags 2'b01 and audio 0xCAFEF00D is received correctly.
- Pin 17 held high for TIMEOUT_CYCLES+10 cycles after W0 -> frame_error pulses once, receiving returns to 0, and no output changes.
- Reset asserted for 1 cycle between W1 and W2 -> all outputs 0 and no pulse. A following complete frame with flags 2'b11, text 0x55, audio 0x00010002 is delivered. With GPIO_RX_FRAME_COUNT_EN defined, frame_count=1.
- Back-to-back frames with one idle word between them, 300 frames -> 300 text pulses, and frame_count reads 300 mod 65536.
